console_arbiter: RTL

Shares the single simulation console byte stream between NUM_PORTS core-side character sources in the manycore platform. Grants one source for a whole line, round-robin. It optionally wraps each line in an ANSI colour prefix and reset suffix so that per-core output stays legible and never interleaves mid-line. It sits between the per-tile debug/print ports and the testbench console sink.

---
 rtl/console_arbiter_pkg.sv | 46 ++++
 rtl/console_arbiter_rr_pick.sv | 29 ++
 rtl/console_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/console_arbiter_pkg.sv
// Shared types, ASCII constants and escape-sequence helpers for the console arbiter.
package console_arbiter_pkg;

   typedef logic [7:0] ubyte_t;

   localparam ubyte_t ESC = 8'h1B;
   localparam ubyte_t LF  = 8'h0A;

   localparam logic [2:0] PREFIX_LAST = 3'd4;  // index of final prefix byte
   localparam logic [2:0] SUFFIX_LAST = 3'd3;  // index of final suffix byte

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PREFIX  = 3'd1,
      ST_PASS    = 3'd2,
      ST_SUFFIX  = 3'd3,
      ST_NEWLINE = 3'd4
   } console_state_t;

   // ANSI bright colour digit: ports 0..5 map to red..cyan, then repeat.
   function automatic ubyte_t color_digit(int p);
      return ubyte_t'(8'h31 + (p % 6));
   endfunction

   // Byte idx of the colour prefix "ESC [ 9 d m".
   function automatic ubyte_t prefix_byte(logic [2:0] idx, int p);
      case (idx)
         3'd0:    return ESC;
         3'd1:    return 8'h5B;
         3'd2:    return 8'h39;
         3'd3:    return color_digit(p);
         default: return 8'h6D;
      endcase
   endfunction

   // Byte idx of the colour reset suffix "ESC [ 0 m".
   function automatic ubyte_t suffix_byte(logic [2:0] idx);
      case (idx)
         3'd0:    return ESC;
         3'd1:    return 8'h5B;
         3'd2:    return 8'h30;
         default: return 8'h6D;
      endcase
   endfunction

endpackage

// File: rtl/console_arbiter_rr_pick.sv
// Combinational round-robin first-one finder: first set request after i_last, wrapping.
module console_arbiter_rr_pick #(
   parameter int unsigned NUM_PORTS = 4
) (
   input  logic [NUM_PORTS-1:0]         i_req,
   input  logic [$clog2(NUM_PORTS)-1:0] i_last,
   output logic                         o_valid,
   output logic [$clog2(NUM_PORTS)-1:0] o_idx
);

   localparam int unsigned GW = $clog2(NUM_PORTS);

   logic [GW-1:0] w_cand;

   // Scan offsets from farthest to nearest so the nearest requester overwrites the others.
   always_comb begin
      o_valid = 1'b0;
      o_idx   = '0;
      w_cand  = '0;
      for (int i = NUM_PORTS; i >= 1; i--) begin
         w_cand = GW'((int'(i_last) + i) % int'(NUM_PORTS));
         if (i_req[w_cand]) begin
            o_valid = 1'b1;
            o_idx   = w_cand;
         end
      end
   end

endmodule

// File: rtl/console_arbiter.sv
// Line-granular round-robin arbiter sharing one console byte stream, with optional ANSI colour.
module console_arbiter
   import console_arbiter_pkg::*;
#(
   parameter int unsigned NUM_PORTS = 4,
   parameter int unsigned TIMEOUT   = 256
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic [NUM_PORTS-1:0]         req_valid,
   input  logic [NUM_PORTS*8-1:0]       req_data,
   output logic [NUM_PORTS-1:0]         req_ready,
   input  logic                         color_en,
   output logic                         out_valid,
   output ubyte_t                       out_data,
   input  logic                         out_ready,
   output logic [$clog2(NUM_PORTS)-1:0] grant_id,
   output logic                         busy
);

   localparam int unsigned GW = $clog2(NUM_PORTS);
   localparam int unsigned IW = $clog2(TIMEOUT + 1);

   console_state_t r_state, w_state_d;
   logic [GW-1:0]  r_grant, w_grant_d;
   logic [GW-1:0]  r_last, w_last_d;
   logic           r_color, w_color_d;
   logic [2:0]     r_cnt, w_cnt_d;
   logic [IW-1:0]  r_idle, w_idle_d;

   logic          w_pick_valid;
   logic [GW-1:0] w_pick;
   ubyte_t        w_byte;
   logic          w_gvalid;
   logic          w_ready_g;
   logic [IW-1:0] w_idle_inc;

   console_arbiter_rr_pick #(
      .NUM_PORTS (NUM_PORTS)
   ) u_rr_pick (
      .i_req   (req_valid),
      .i_last  (r_last),
      .o_valid (w_pick_valid),
      .o_idx   (w_pick)
   );

   // Select the granted source's byte and valid.
   always_comb begin
      w_byte   = '0;
      w_gvalid = 1'b0;
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
         if (r_grant == GW'(p)) begin
            w_byte   = req_data[8*p +: 8];
            w_gvalid = req_valid[p];
         end
      end
   end

   // Route the granted ready back to its source only.
   always_comb begin
      req_ready = '0;
      for (int p = 0; p < int'(NUM_PORTS); p++) begin
         req_ready[p] = w_ready_g && (r_grant == GW'(p));
      end
   end

   assign w_idle_inc = r_idle + 1'b1;
   assign grant_id   = r_grant;
   assign busy       = (r_state != ST_IDLE);

   // Next-state logic and console output mux.
   always_comb begin
      w_state_d = r_state;
      w_grant_d = r_grant;
      w_last_d  = r_last;
      w_color_d = r_color;
      w_cnt_d   = r_cnt;
      w_idle_d  = r_idle;
      w_ready_g = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_pick_valid) begin
               w_grant_d = w_pick;
               w_last_d  = w_pick;
               w_color_d = color_en;
               w_cnt_d   = '0;
               w_idle_d  = '0;
               w_state_d = color_en ? ST_PREFIX : ST_PASS;
            end
         end
         ST_PREFIX: begin
            out_valid = 1'b1;
            out_data  = prefix_byte(r_cnt, int'(r_grant));
            if (out_ready) begin
               if (r_cnt == PREFIX_LAST) begin
                  w_cnt_d   = '0;
                  w_state_d = ST_PASS;
               end else begin
                  w_cnt_d = r_cnt + 3'd1;
               end
            end
         end
         ST_PASS: begin
            if (r_color && (w_byte == LF)) begin
               // Swallow the source newline; it is re-emitted after the colour reset.
               w_ready_g = 1'b1;
               if (w_gvalid) begin
                  w_cnt_d   = '0;
                  w_state_d = ST_SUFFIX;
               end
            end else begin
               out_valid = w_gvalid;
               out_data  = w_byte;
               w_ready_g = out_ready;
               if (w_gvalid && out_ready && (w_byte == LF)) begin
                  w_state_d = ST_IDLE;
               end
            end
            if (w_gvalid) begin
               if (w_ready_g) begin
                  w_idle_d = '0;
               end
            end else if (w_idle_inc == IW'(TIMEOUT)) begin
               w_idle_d  = '0;
               w_cnt_d   = '0;
               w_state_d = r_color ? ST_SUFFIX : ST_NEWLINE;
            end else begin
               w_idle_d = w_idle_inc;
            end
         end
         ST_SUFFIX: begin
            out_valid = 1'b1;
            out_data  = suffix_byte(r_cnt);
            if (out_ready) begin
               if (r_cnt == SUFFIX_LAST) begin
                  w_cnt_d   = '0;
                  w_state_d = ST_NEWLINE;
               end else begin
                  w_cnt_d = r_cnt + 3'd1;
               end
            end
         end
         ST_NEWLINE: begin
            out_valid = 1'b1;
            out_data  = LF;
            if (out_ready) begin
               w_state_d = ST_IDLE;
            end
         end
         default: w_state_d = ST_IDLE;
      endcase
   end

   // State registers; last grant resets to the top port so port 0 wins the first tie.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_last  <= GW'(NUM_PORTS - 1);
         r_color <= 1'b0;
         r_cnt   <= '0;
         r_idle  <= '0;
      end else begin
         r_state <= w_state_d;
         r_grant <= w_grant_d;
         r_last  <= w_last_d;
         r_color <= w_color_d;
         r_cnt   <= w_cnt_d;
         r_idle  <= w_idle_d;
      end
   end

endmodule
